// File: rtl/montgomery_mul_pkg.sv
// montgomery_mul_pkg: shared widths, iteration count, latency and FSM state encodings
package montgomery_mul_pkg;
  localparam int MM_WIDTH = 512;
  localparam int MM_ADD_W = MM_WIDTH + 2;
  localparam int MM_ITER = MM_WIDTH;
  localparam int MM_LATENCY = 4 * MM_ITER + 2;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDB_ISSUE = 3'd1;
  localparam logic [2:0] S_ADDB_WAIT = 3'd2;
  localparam logic [2:0] S_ADDM_ISSUE = 3'd3;
  localparam logic [2:0] S_ADDM_WAIT = 3'd4;
  localparam logic [2:0] S_SUB_ISSUE = 3'd5;
  localparam logic [2:0] S_SUB_WAIT = 3'd6;
endpackage

// File: rtl/montgomery_mul_adder.sv
// montgomery_mul_adder: registered wide adder, result = in_a + in_b + subtract, optional >>1
// Ports: clk, resetn (sync, active-low), start, in_a/in_b [AW-1:0], subtract, shift,
//        result [AW:0] (top bit is borrow-flag when subtracting), done (one cycle after start).
module montgomery_mul_adder
  import montgomery_mul_pkg::*;
#(
  parameter int AW = MM_ADD_W
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  input  logic          subtract,
  input  logic          shift,
  output logic [AW:0]   result,
  output logic          done
);
  logic [AW:0] sum;
  logic [AW:0] x;
  always_comb begin
    sum = {1'b0, in_a} + {1'b0, in_b} + (AW+1)'(subtract);
    x = {sum[AW] ^ subtract, sum[AW-1:0]};
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result <= '0;
      done <= 1'b0;
    end else begin
      done <= start;
      if (start) result <= shift ? x >> 1 : x;
    end
  end
endmodule

// File: rtl/montgomery_mul.sv
// montgomery_mul: bit-serial Montgomery multiplier, result = A*B*2^-WIDTH mod M
// Ports: clk, resetn (sync, active-low), start (sampled in IDLE), in_a/in_b/in_m [WIDTH-1:0]
//        (M odd, A,B < M), result [WIDTH-1:0] (held between completions), done (one-cycle pulse).
module montgomery_mul
  import montgomery_mul_pkg::*;
#(
  parameter int WIDTH = MM_WIDTH,
  parameter int ITER = WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);
  localparam int AW = WIDTH + 2;
  localparam int IW = $clog2(ITER);
  logic [2:0] state;
  logic [IW-1:0] i;
  logic [WIDTH-1:0] a_r, b_r, m_r;
  logic [AW-1:0] c;
  logic [AW-1:0] op_b;
  logic [AW:0] add_res;
  logic add_start, add_done, add_sub, add_shift;
  // Both additions run every iteration (adding zero when skipped) to keep latency fixed.
  always_comb begin
    add_start = state == S_ADDB_ISSUE || state == S_ADDM_ISSUE || state == S_SUB_ISSUE;
    add_sub = state == S_SUB_ISSUE;
    add_shift = state == S_ADDM_ISSUE;
    op_b = add_sub ? ~{2'b0, m_r} :
           add_shift ? (c[0] ? {2'b0, m_r} : '0) :
           (a_r[i] ? {2'b0, b_r} : '0);
  end
  montgomery_mul_adder #(.AW(AW)) adder (
    .clk(clk),
    .resetn(resetn),
    .start(add_start),
    .in_a(c),
    .in_b(op_b),
    .subtract(add_sub),
    .shift(add_shift),
    .result(add_res),
    .done(add_done)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      i <= '0;
      c <= '0;
      a_r <= '0;
      b_r <= '0;
      m_r <= '0;
      result <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          a_r <= in_a;
          b_r <= in_b;
          m_r <= in_m;
          c <= '0;
          i <= '0;
          state <= S_ADDB_ISSUE;
        end
        S_ADDB_ISSUE: state <= S_ADDB_WAIT;
        S_ADDB_WAIT: if (add_done) begin
          c <= add_res[AW-1:0];
          state <= S_ADDM_ISSUE;
        end
        S_ADDM_ISSUE: state <= S_ADDM_WAIT;
        S_ADDM_WAIT: if (add_done) begin
          c <= add_res[AW-1:0];
          i <= i + 1'b1;
          state <= i == IW'(ITER - 1) ? S_SUB_ISSUE : S_ADDB_ISSUE;
        end
        S_SUB_ISSUE: state <= S_SUB_WAIT;
        S_SUB_WAIT: if (add_done) begin
          // Top bit set means C - M borrowed, so C is already reduced.
          result <= add_res[AW] ? c[WIDTH-1:0] : add_res[WIDTH-1:0];
          done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/montgomery_mul.md
MONTGOMERY_MUL -- requirements
Module: montgomery_mul

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; resetn  in  1  synchronous, active-low reset.
REQ-002 SHALL have port: start  in  1  one-cycle request; sampled only in IDLE.
REQ-003 SHALL have ports: in_a, in_b, in_m  in  512 each  operands A, B and odd modulus M; require A, B < M.
REQ-004 SHALL have ports: result  out  512  A*B*2^-512 mod M; done  out  1  one-cycle completion pulse.
REQ-005 SHALL have parameters: WIDTH, default 512, operand width; ITER, default WIDTH, iteration count.

Function
REQ-006 SHALL latch A, B and M on the edge that samples start=1 in IDLE; later port changes SHALL have no effect until the next accepted start.
REQ-007 SHALL use a 514-bit accumulator C, cleared at start and bounded C < 2M for the whole operation.
REQ-008 SHALL perform iteration i = 0..511, with a_i = bit i of latched A: C1 = C + (a_i ? B : 0), then C = (C1 + (C1[0] ? M : 0)) >> 1.
REQ-009 SHALL run each adder operation as two states: ISSUE (adder start=1, operands driven) and WAIT (capture the adder result when adder done=1).
REQ-010 SHALL use these states and transitions: IDLE -> ADDB_ISSUE -> ADDB_WAIT -> ADDM_ISSUE -> ADDM_WAIT; back to ADDB_ISSUE while i < 511, else SUB_ISSUE -> SUB_WAIT -> IDLE.
REQ-011 SHALL issue both adder operations in every iteration, adding zero when a_i=0 or C1[0]=0, so latency is data-independent.
REQ-012 SHALL run ADDB with subtract=0, shift=0; ADDM with subtract=0, shift=1; the shifted adder output bits [513:0] become C.
REQ-013 SHALL run the final step as D = C + ~{2'b0, M} + 1 (subtract=1, shift=0, in_b = bitwise inverse of zero-extended M).
REQ-014 SHALL load result from D[511:0] when adder result bit 514 = 0 (no borrow, C >= M), else from C[511:0].
REQ-015 SHALL assert done for exactly one cycle, registered, on the 2050th rising edge after the edge that sampled start.
REQ-016 SHALL hold result stable from done until the next done; result SHALL NOT change during a computation.
REQ-017 SHALL ignore start while not in IDLE, with no restart and no latency change.
REQ-018 SHALL accept a start sampled in the same cycle that done is high, since the FSM is already in IDLE.
REQ-019 SHALL compute the pre-correction value 2M, and never 514-bit wrap-around, when C1 + M exceeds 2^513.

Reset
REQ-020 SHALL, on resetn=0 at a rising edge, force state IDLE, i=0, C=0, result=0, done=0 and reset the adder instance.
REQ-021 SHALL abort any computation when reset occurs mid-operation, produce no done pulse for it, and accept a new start on the first edge with resetn=1.

Structure
REQ-022 SHALL place WIDTH, the adder width 514, ITER, the latency constant 2050 and the state encodings in the shared package/header.
REQ-023 SHALL instantiate exactly one sub-module, adder, with this contract: registered result = in_a + in_b + subtract (515 bits); bit 514 XOR subtract; shift drops bit 0; done one cycle after start.
REQ-024 SHALL implement the FSM, iteration counter, operand registers, zero/M/~M input muxing and final select in montgomery_mul itself.

Verification
REQ-025 SHALL check: M=2^512-1, A=5, B=7, start -> done at edge 2050, result=35.
REQ-026 SHALL check: M=2^512-1, A=B=M-1 -> result=1 (final subtraction path exercised).
REQ-027 SHALL check: A=0, any odd M, B=M-1 -> result=0; 1000 random odd M and A,B<M -> result matches golden A*B*2^-512 mod M, always < M.
REQ-028 SHALL check: start pulsed at edges 10 and 500 during an operation -> single done at the original 2050 count, result unaffected.
REQ-029 SHALL check: resetn=0 at edge 1000 -> done stays 0, result=0; new start (A=5, B=7, M=2^512-1) -> result=35 after 2050 edges.
REQ-030 SHALL check: start asserted in the done cycle -> second operation accepted, second done 2050 edges later.
